// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the two write-back producers, the arbiter and the register-file write port.
// The master side is the producer/consumer environment; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
    parameter int NREG   = 16,
    parameter int DATA_W = 8
);
    localparam int AW = $clog2(NREG);

    logic              req0_valid;
    logic [AW-1:0]     req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [AW-1:0]     req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              rf_write_en;
    logic [AW-1:0]     rf_wr_addr;
    logic [DATA_W-1:0] rf_val_in;
    logic [NREG-1:0]   pending;
    logic              idle;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_write_en, rf_wr_addr, rf_val_in, pending, idle
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_write_en, rf_wr_addr, rf_val_in, pending, idle
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: two per-requester FIFOs share one registered register-file
// write port, with a pending-write scoreboard so decode can stall on in-flight destinations.
module rf_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int NREG   = 16,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][AW-1:0]     addr_mem [2];
    logic [DEPTH-1:0][DATA_W-1:0] data_mem [2];
    logic [1:0][PW-1:0]           wr_ptr;
    logic [1:0][PW-1:0]           rd_ptr;
    logic [1:0][CW-1:0]           count;
    logic                         last_grant;

    logic [1:0]                   req_valid;
    logic [1:0][AW-1:0]           req_addr;
    logic [1:0][DATA_W-1:0]       req_data;
    logic [1:0]                   push;
    logic [1:0]                   grant;
    logic [1:0]                   full;
    logic [1:0]                   not_empty;

    logic                         rf_write_en_q;
    logic [AW-1:0]                rf_wr_addr_q;
    logic [DATA_W-1:0]            rf_val_in_q;
    logic [NREG-1:0]              pending_c;
    logic [PW-1:0]                occ_off;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_addr  = {bus.req1_addr,  bus.req0_addr};
    assign req_data  = {bus.req1_data,  bus.req0_data};

    // Ready comes from the registered count only, so a popping full FIFO still refuses a push.
    always_comb begin
        full      = '0;
        not_empty = '0;
        push      = '0;
        grant     = '0;
        for (int i = 0; i < 2; i++) begin
            full[i]      = (count[i] == FULL_CNT);
            not_empty[i] = (count[i] != '0);
            push[i]      = req_valid[i] && !full[i];
        end
        grant[0] = not_empty[0] && (!not_empty[1] || last_grant);
        grant[1] = not_empty[1] && (!not_empty[0] || !last_grant);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                addr_mem[i][wr_ptr[i]] <= req_addr[i];
                data_mem[i][wr_ptr[i]] <= req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_grant    <= 1'b1;
            rf_write_en_q <= 1'b0;
            rf_wr_addr_q  <= '0;
            rf_val_in_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (grant[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !grant[i])
                    count[i] <= count[i] + 1'b1;
                else if (!push[i] && grant[i])
                    count[i] <= count[i] - 1'b1;
            end
            rf_write_en_q <= |grant;
            if (grant[1]) begin
                rf_wr_addr_q <= addr_mem[1][rd_ptr[1]];
                rf_val_in_q  <= data_mem[1][rd_ptr[1]];
                last_grant   <= 1'b1;
            end else if (grant[0]) begin
                rf_wr_addr_q <= addr_mem[0][rd_ptr[0]];
                rf_val_in_q  <= data_mem[0][rd_ptr[0]];
                last_grant   <= 1'b0;
            end
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        pending_c = '0;
        occ_off   = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                occ_off = PW'(k) - rd_ptr[i];
                if ({1'b0, occ_off} < count[i])
                    pending_c[addr_mem[i][k]] = 1'b1;
            end
        end
        if (rf_write_en_q)
            pending_c[rf_wr_addr_q] = 1'b1;
    end

    assign bus.req0_ready  = !full[0];
    assign bus.req1_ready  = !full[1];
    assign bus.rf_write_en = rf_write_en_q;
    assign bus.rf_wr_addr  = rf_wr_addr_q;
    assign bus.rf_val_in   = rf_val_in_q;
    assign bus.pending     = pending_c;
    assign bus.idle        = (count[0] == '0) && (count[1] == '0) && !rf_write_en_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a DEPTH=2 instance for reset, latency, contention,
// back-pressure and same-address ordering, and a DEPTH=4 instance for pointer wrap.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NREG(16), .DATA_W(8)) a_if ();
    rf_wb_arbiter_if #(.NREG(16), .DATA_W(8)) b_if ();

    rf_wb_arbiter #(.DEPTH(2), .NREG(16), .DATA_W(8)) dut  (.clk(clk), .reset(reset), .bus(a_if.slave));
    rf_wb_arbiter #(.DEPTH(4), .NREG(16), .DATA_W(8)) dut4 (.clk(clk), .reset(reset), .bus(b_if.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  rf_model [16];
    logic [11:0] log_a [$];
    logic [11:0] log_b [$];

    // Register file and port monitors see the values present at the sampling edge.
    always @(posedge clk) begin
        if (a_if.rf_write_en) begin
            rf_model[a_if.rf_wr_addr] <= a_if.rf_val_in;
            log_a.push_back({a_if.rf_wr_addr, a_if.rf_val_in});
        end
        if (b_if.rf_write_en)
            log_b.push_back({b_if.rf_wr_addr, b_if.rf_val_in});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_if.req0_valid = 1'b0; a_if.req0_addr = '0; a_if.req0_data = '0;
        a_if.req1_valid = 1'b0; a_if.req1_addr = '0; a_if.req1_data = '0;
        b_if.req0_valid = 1'b0; b_if.req0_addr = '0; b_if.req0_data = '0;
        b_if.req1_valid = 1'b0; b_if.req1_addr = '0; b_if.req1_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit use_b);
        int n;
        n = 0;
        while (!(use_b ? b_if.idle : a_if.idle) && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(use_b ? b_if.idle : a_if.idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i0, i1, cyc, lows, errs;
        bit f0, f1;
        logic [7:0]  bp_exp [6];
        logic [11:0] got;

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_we",      32'(a_if.rf_write_en), 32'd0);
        chk("rst_pending", 32'(a_if.pending),     32'd0);
        chk("rst_idle",    32'(a_if.idle),        32'd1);
        chk("rst_rdy0",    32'(a_if.req0_ready),  32'd1);
        chk("rst_rdy1",    32'(a_if.req1_ready),  32'd1);
        chk("rst_addr",    32'(a_if.rf_wr_addr),  32'd0);
        reset = 1'b0;

        // Single write: push at edge N, port at N+1..N+2, cleared after.
        a_if.req0_valid = 1'b1; a_if.req0_addr = 4'd5; a_if.req0_data = 8'hA3;
        tick();
        a_if.req0_valid = 1'b0;
        chk("sw_pend5_n",  32'(a_if.pending[5]),  32'd1);
        chk("sw_we_n",     32'(a_if.rf_write_en), 32'd0);
        chk("sw_idle_n",   32'(a_if.idle),        32'd0);
        tick();
        chk("sw_port",     32'({a_if.rf_write_en, a_if.rf_wr_addr, a_if.rf_val_in}), 32'({1'b1, 4'd5, 8'hA3}));
        chk("sw_pend5_p",  32'(a_if.pending[5]),  32'd1);
        tick();
        chk("sw_we_off",   32'(a_if.rf_write_en), 32'd0);
        chk("sw_pend_clr", 32'(a_if.pending),     32'd0);
        chk("sw_idle",     32'(a_if.idle),        32'd1);
        chk("sw_rf5",      32'(rf_model[5]),      32'hA3);

        // Reset with two entries queued discards them.
        a_if.req0_valid = 1'b1; a_if.req0_addr = 4'd9;  a_if.req0_data = 8'h55;
        a_if.req1_valid = 1'b1; a_if.req1_addr = 4'd10; a_if.req1_data = 8'h66;
        tick();
        clear_inputs();
        chk("rq_pending", 32'(a_if.pending), 32'h0600);
        do_reset();
        log_a.delete();
        chk("rq_idle",    32'(a_if.idle),        32'd1);
        chk("rq_pending0",32'(a_if.pending),     32'd0);
        chk("rq_we",      32'(a_if.rf_write_en), 32'd0);
        tick(); tick(); tick();
        chk("rq_nowrites", 32'(log_a.size()), 32'd0);

        // Contention: strict alternation starting with req0.
        log_a.delete();
        i0 = 0; i1 = 0; cyc = 0;
        while ((i0 < 4 || i1 < 4) && cyc < 40) begin
            a_if.req0_valid = (i0 < 4); a_if.req0_addr = 4'd1; a_if.req0_data = 8'(8'h10 + i0);
            a_if.req1_valid = (i1 < 4); a_if.req1_addr = 4'd2; a_if.req1_data = 8'(8'h20 + i1);
            f0 = a_if.req0_valid && a_if.req0_ready;
            f1 = a_if.req1_valid && a_if.req1_ready;
            tick();
            if (f0) i0++;
            if (f1) i1++;
            cyc++;
        end
        clear_inputs();
        wait_idle("cont_idle", 1'b0);
        chk("cont_len", 32'(log_a.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            got = (i < log_a.size()) ? log_a[i] : 12'hFFF;
            chk($sformatf("cont_%0d", i), 32'(got[7:0]),
                (i % 2 == 0) ? 32'(8'h10 + i / 2) : 32'(8'h20 + i / 2));
        end

        // Back-pressure on req1 while req0 keeps pushing.
        do_reset();
        log_a.delete();
        bp_exp = '{8'h40, 8'h31, 8'h41, 8'h32, 8'h42, 8'h43};
        i0 = 0; i1 = 0;
        for (int c = 1; c <= 12; c++) begin
            a_if.req0_valid = (i0 < 4); a_if.req0_addr = 4'd0; a_if.req0_data = 8'(8'h40 + i0);
            a_if.req1_valid = (i1 < 2); a_if.req1_addr = 4'd3; a_if.req1_data = 8'(8'h31 + i1);
            f0 = a_if.req0_valid && a_if.req0_ready;
            f1 = a_if.req1_valid && a_if.req1_ready;
            tick();
            if (f0) i0++;
            if (f1) i1++;
            case (c)
                2: begin
                    chk("bp_rdy1_low", 32'(a_if.req1_ready), 32'd0);
                    chk("bp_pend3_a",  32'(a_if.pending[3]), 32'd1);
                end
                3: begin
                    chk("bp_rdy1_up", 32'(a_if.req1_ready), 32'd1);
                    chk("bp_w1", 32'({a_if.rf_write_en, a_if.rf_wr_addr, a_if.rf_val_in}), 32'({1'b1, 4'd3, 8'h31}));
                end
                4: chk("bp_pend3_b", 32'(a_if.pending[3]), 32'd1);
                5: begin
                    chk("bp_w2", 32'({a_if.rf_write_en, a_if.rf_wr_addr, a_if.rf_val_in}), 32'({1'b1, 4'd3, 8'h32}));
                    chk("bp_pend3_c", 32'(a_if.pending[3]), 32'd1);
                end
                6: chk("bp_pend3_clr", 32'(a_if.pending[3]), 32'd0);
                default: ;
            endcase
        end
        clear_inputs();
        wait_idle("bp_idle", 1'b0);
        chk("bp_len", 32'(log_a.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            got = (i < log_a.size()) ? log_a[i] : 12'hFFF;
            chk($sformatf("bp_order_%0d", i), 32'(got[7:0]), 32'(bp_exp[i]));
        end

        // Same-address race: req0 wins first, last write is req1's.
        do_reset();
        a_if.req0_valid = 1'b1; a_if.req0_addr = 4'd7; a_if.req0_data = 8'h01;
        a_if.req1_valid = 1'b1; a_if.req1_addr = 4'd7; a_if.req1_data = 8'h02;
        tick();
        clear_inputs();
        chk("race_pend_a", 32'(a_if.pending[7]), 32'd1);
        tick();
        chk("race_w1", 32'({a_if.rf_write_en, a_if.rf_wr_addr, a_if.rf_val_in}), 32'({1'b1, 4'd7, 8'h01}));
        chk("race_pend_b", 32'(a_if.pending[7]), 32'd1);
        tick();
        chk("race_w2", 32'({a_if.rf_write_en, a_if.rf_wr_addr, a_if.rf_val_in}), 32'({1'b1, 4'd7, 8'h02}));
        chk("race_pend_c", 32'(a_if.pending[7]), 32'd1);
        tick();
        chk("race_we_off", 32'(a_if.rf_write_en), 32'd0);
        chk("race_pend_clr", 32'(a_if.pending[7]), 32'd0);
        chk("race_rf7", 32'(rf_model[7]), 32'h02);

        // Pointer wrap on the DEPTH=4 instance: 20 back-to-back req0 writes.
        log_b.delete();
        i0 = 0; cyc = 0; lows = 0;
        while (i0 < 20 && cyc < 60) begin
            b_if.req0_valid = 1'b1;
            b_if.req0_addr  = 4'(i0 % 16);
            b_if.req0_data  = 8'(8'h80 + i0);
            if (!b_if.req0_ready) lows++;
            f0 = b_if.req0_ready;
            tick();
            if (f0) i0++;
            cyc++;
        end
        clear_inputs();
        wait_idle("wrap_idle", 1'b1);
        chk("wrap_rdy_low", 32'(lows), 32'd0);
        chk("wrap_len", 32'(log_b.size()), 32'd20);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            got = (i < log_b.size()) ? log_b[i] : 12'hFFF;
            if (got !== {4'(i % 16), 8'(8'h80 + i)}) errs++;
        end
        chk("wrap_order_errs", 32'(errs), 32'd0);
        chk("wrap_pending", 32'(b_if.pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
